cpu_core: RTL and testbench

Multi-cycle 32-bit load/store processor with a single word-addressed memory port shared by instruction fetch and data access. Sits at the top of the design and drives a synchronous memory or ROM that returns read data one clock after the request. Executes a fixed 32-bit instruction set from a 16-entry register file, starting at word address 0 after reset.

---
 rtl/cpu_core.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_core.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : cpu_core
// Description : Multi-cycle 32-bit load/store processor. It has one
//               word-addressed memory port that is shared by instruction
//               fetch and data access. The memory returns read data one
//               clock after the request. The core has a 16-entry register
//               file (r0 is hardwired to zero) and starts at word address 0
//               after reset.
//               Optional feature macro: CPU_MUL_EN. When defined, ALU fn B
//               is a single-cycle 32x32 multiply (low word). When undefined,
//               fn B behaves as MOV.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_core (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_re,
    output logic        mem_we,
    output logic [29:0] memaddr,
    input  logic [31:0] rmemdata,
    output logic [31:0] wmemdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_FWAIT = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_LWAIT = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam logic [3:0] C_ALUR   = 4'h0;
    localparam logic [3:0] C_ALUI   = 4'h1;
    localparam logic [3:0] C_LOAD   = 4'h2;
    localparam logic [3:0] C_STORE  = 4'h3;
    localparam logic [3:0] C_BRANCH = 4'h4;
    localparam logic [3:0] C_JREG   = 4'h5;
    localparam logic [3:0] C_LUI    = 4'h6;
    localparam logic [3:0] C_HALT   = 4'hF;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [29:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_rf [0:15];

    // Instruction fields
    logic [3:0]  w_cls, w_fn, w_rd, w_ra, w_rb;
    logic [15:0] w_imm;
    logic [31:0] w_simm;
    assign w_cls  = r_ir[31:28];
    assign w_fn   = r_ir[27:24];
    assign w_rd   = r_ir[23:20];
    assign w_ra   = r_ir[19:16];
    assign w_rb   = r_ir[15:12];
    assign w_imm  = r_ir[15:0];
    assign w_simm = {{16{w_imm[15]}}, w_imm};

    // Operands are read before any writeback in the same cycle. r_rf[0]
    // is never written after reset, so it always reads as zero.
    logic [31:0] w_a, w_b, w_d;
    assign w_a = r_rf[w_ra];
    assign w_d = r_rf[w_rd];
    assign w_b = (w_cls == C_ALUR) ? r_rf[w_rb] : w_simm;

    logic [29:0] w_ea, w_pc_inc, w_br_tgt;
    logic [31:0] w_link;
    assign w_ea     = w_a[29:0] + w_simm[29:0];
    assign w_pc_inc = r_pc + 30'd1;
    assign w_br_tgt = w_pc_inc + w_simm[29:0];
    assign w_link   = {2'b00, w_pc_inc};

    // ALU result for register and immediate forms
    logic [31:0] w_alu;
    always_comb begin
        w_alu = w_b;
        case (w_fn)
            4'h0: w_alu = w_a + w_b;
            4'h1: w_alu = w_a - w_b;
            4'h2: w_alu = w_a & w_b;
            4'h3: w_alu = w_a | w_b;
            4'h4: w_alu = w_a ^ w_b;
            4'h5: w_alu = w_a << w_b[4:0];
            4'h6: w_alu = w_a >> w_b[4:0];
            4'h7: w_alu = $unsigned($signed(w_a) >>> w_b[4:0]);
            4'h8: w_alu = {31'd0, ($signed(w_a) < $signed(w_b))};
            4'h9: w_alu = {31'd0, (w_a < w_b)};
`ifdef CPU_MUL_EN
            4'hB: w_alu = w_a * w_b;
`endif
            default: w_alu = w_b;
        endcase
    end

    // Branch condition evaluated on ra
    logic w_taken;
    always_comb begin
        w_taken = 1'b0;
        case (w_fn)
            4'h0:    w_taken = 1'b1;
            4'h1:    w_taken = (w_a == 32'd0);
            4'h2:    w_taken = (w_a != 32'd0);
            4'h3:    w_taken = w_a[31];
            4'h4:    w_taken = ~w_a[31];
            default: w_taken = 1'b0;
        endcase
    end

    // Writeback and PC selection: EXEC results, or load data in LWAIT
    logic        w_wen, w_pc_we;
    logic [31:0] w_wdata;
    logic [29:0] w_pc_nxt;
    always_comb begin
        w_wen    = 1'b0;
        w_wdata  = '0;
        w_pc_we  = 1'b0;
        w_pc_nxt = r_pc;
        if (r_state == S_EXEC) begin
            w_pc_we  = 1'b1;
            w_pc_nxt = w_pc_inc;
            case (w_cls)
                C_ALUR, C_ALUI: begin
                    w_wen   = 1'b1;
                    w_wdata = w_alu;
                end
                C_BRANCH: begin
                    w_wen   = 1'b1;
                    w_wdata = w_link;
                    if (w_taken) w_pc_nxt = w_br_tgt;
                end
                C_JREG: begin
                    w_wen    = 1'b1;
                    w_wdata  = w_link;
                    w_pc_nxt = w_a[29:0];
                end
                C_LUI: begin
                    w_wen   = 1'b1;
                    w_wdata = {w_imm, 16'h0000};
                end
                default: ;
            endcase
        end else if (r_state == S_LWAIT) begin
            w_wen   = 1'b1;
            w_wdata = rmemdata;
        end
    end

    // Next state and memory port, decoded from the current state
    always_comb begin
        w_state_nxt = r_state;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        memaddr     = '0;
        wmemdata    = '0;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: begin
                mem_re      = 1'b1;
                memaddr     = r_pc;
                w_state_nxt = S_FWAIT;
            end
            S_FWAIT: w_state_nxt = S_EXEC;
            S_EXEC: begin
                case (w_cls)
                    C_LOAD: begin
                        mem_re      = 1'b1;
                        memaddr     = w_ea;
                        w_state_nxt = S_LWAIT;
                    end
                    C_STORE: begin
                        mem_we      = 1'b1;
                        memaddr     = w_ea;
                        wmemdata    = w_d;
                        w_state_nxt = S_FETCH;
                    end
                    C_HALT:  w_state_nxt = S_HALT;
                    default: w_state_nxt = S_FETCH;
                endcase
            end
            S_LWAIT: w_state_nxt = S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Architectural state: IR capture, PC update, register-file write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
            r_ir <= '0;
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else begin
            if (r_state == S_FWAIT) r_ir <= rmemdata;
            if (w_pc_we) r_pc <= w_pc_nxt;
            if (w_wen && (w_rd != 4'd0)) r_rf[w_rd] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_core
// Description : Self-checking bench for cpu_core. It uses a synchronous
//               memory model and an instruction-level reference interpreter
//               that predicts every bus cycle. A table of ALU vectors is also
//               applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_re, mem_we;
    logic [29:0] memaddr;
    logic [31:0] rmemdata;
    logic [31:0] wmemdata;

    cpu_core dut (
        .clk      (clk),
        .rst      (rst),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .memaddr  (memaddr),
        .rmemdata (rmemdata),
        .wmemdata (wmemdata)
    );

    always #5 clk = ~clk;

    // Program image (written by the test) and the live memory (reloaded in reset)
    logic [31:0] image [0:255];
    logic [31:0] mem   [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= image[i];
        end else begin
            if (mem_we) mem[memaddr[7:0]] <= wmemdata;
            if (mem_re) rmemdata <= mem[memaddr[7:0]];
        end
    end

    typedef struct {
        int          cyc;
        logic        re;
        logic        we;
        logic [29:0] addr;
        logic [31:0] data;
    } bus_ev_t;

    bus_ev_t act_q[$];
    bus_ev_t exp_q[$];
    int      tick = 0;
    int      base = 0;
    int      act_start = 0;
    logic    mon_en = 1'b0;

    always @(posedge clk) tick <= tick + 1;

    // Record every active bus cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en && (mem_re || mem_we))
            act_q.push_back('{tick - base, mem_re, mem_we, memaddr, (mem_we ? wmemdata : 32'h0)});
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] enc(input logic [3:0] c, input logic [3:0] f,
                                        input logic [3:0] d, input logic [3:0] a,
                                        input logic [15:0] lo);
        return {c, f, d, a, lo};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = b % 32;
        case (fn)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: return $unsigned($signed(a) >>> sh);
            4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
`ifdef CPU_MUL_EN
            4'hB: return a * b;
`endif
            default: return b;
        endcase
    endfunction

    function automatic logic cond_ref(input logic [3:0] fn, input logic [31:0] a);
        case (fn)
            4'h0: return 1'b1;
            4'h1: return a == 0;
            4'h2: return a != 0;
            4'h3: return $signed(a) < 0;
            4'h4: return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level interpreter: predicts every bus event and its cycle
    task automatic model_run(output int end_cyc);
        logic [31:0] mm [0:255];
        logic [31:0] rf [0:15];
        logic [29:0] pc, nxt, link, ea;
        logic [31:0] ir, a, b, d, s, wv;
        logic [3:0]  cls, fn, rd;
        logic        wen, done;
        int          cyc, len;
        for (int i = 0; i < 256; i++) mm[i] = image[i];
        for (int i = 0; i < 16; i++) rf[i] = 0;
        exp_q.delete();
        pc = 0; cyc = 1; done = 1'b0; end_cyc = 600;
        for (int n = 0; n < 200 && !done; n++) begin
            ir = mm[pc[7:0]];
            exp_q.push_back('{cyc, 1'b1, 1'b0, pc, 32'h0});
            cls = ir[31:28]; fn = ir[27:24]; rd = ir[23:20];
            a = rf[ir[19:16]]; b = rf[ir[15:12]]; d = rf[rd];
            s = {{16{ir[15]}}, ir[15:0]};
            link = pc + 1;
            ea = a + s;
            nxt = link; len = 3; wen = 1'b0; wv = 0;
            case (cls)
                4'h0: begin wen = 1'b1; wv = alu_ref(fn, a, b); end
                4'h1: begin wen = 1'b1; wv = alu_ref(fn, a, s); end
                4'h2: begin
                    exp_q.push_back('{cyc + 2, 1'b1, 1'b0, ea, 32'h0});
                    wen = 1'b1; wv = mm[ea[7:0]]; len = 4;
                end
                4'h3: begin
                    exp_q.push_back('{cyc + 2, 1'b0, 1'b1, ea, d});
                    mm[ea[7:0]] = d;
                end
                4'h4: begin
                    wen = 1'b1; wv = {2'b00, link};
                    if (cond_ref(fn, a)) nxt = link + s[29:0];
                end
                4'h5: begin wen = 1'b1; wv = {2'b00, link}; nxt = a[29:0]; end
                4'h6: begin wen = 1'b1; wv = {ir[15:0], 16'h0}; end
                4'hF: begin done = 1'b1; end_cyc = cyc + 2; end
                default: ;
            endcase
            if (wen && rd != 0) rf[rd] = wv;
            pc = nxt;
            cyc += len;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Hold reset two cycles, check idle outputs, release and run ncyc cycles
    task automatic run_prog(input int ncyc);
        rst = 1'b1;
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_re", {31'd0, mem_re}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_memaddr", {2'b00, memaddr}, 32'd0);
        check("reset_wmemdata", wmemdata, 32'd0);
        act_start = act_q.size();
        base = tick;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    task automatic check_trace(input string name);
        int n_act, n;
        bus_ev_t ga, ge;
        n_act = act_q.size() - act_start;
        n = (n_act > exp_q.size()) ? n_act : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (i >= n_act) begin
                ge = exp_q[i];
                n_err++;
                $display("FAIL %s[%0d]: no bus cycle seen, expected cyc=%0d re=%0b we=%0b addr=%h data=%h",
                         name, i, ge.cyc, ge.re, ge.we, ge.addr, ge.data);
            end else if (i >= exp_q.size()) begin
                ga = act_q[act_start + i];
                n_err++;
                $display("FAIL %s[%0d]: got cyc=%0d re=%0b we=%0b addr=%h data=%h, expected no bus cycle",
                         name, i, ga.cyc, ga.re, ga.we, ga.addr, ga.data);
            end else begin
                ga = act_q[act_start + i];
                ge = exp_q[i];
                if (ga.cyc != ge.cyc || ga.re !== ge.re || ga.we !== ge.we ||
                    ga.addr !== ge.addr || ga.data !== ge.data) begin
                    n_err++;
                    $display("FAIL %s[%0d]: got cyc=%0d re=%0b we=%0b addr=%h data=%h, expected cyc=%0d re=%0b we=%0b addr=%h data=%h",
                             name, i, ga.cyc, ga.re, ga.we, ga.addr, ga.data,
                             ge.cyc, ge.re, ge.we, ge.addr, ge.data);
                end
            end
        end
    endtask

    // Last value the DUT wrote to a given address during the latest run
    task automatic find_store(input logic [29:0] addr, output logic [31:0] data);
        data = 32'hxxxx_xxxx;
        for (int i = act_start; i < act_q.size(); i++)
            if (act_q[i].we && act_q[i].addr == addr) data = act_q[i].data;
    endtask

    task automatic clear_image();
        for (int i = 0; i < 256; i++) image[i] = 32'h7000_0000;
    endtask

    typedef struct {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t tbl [13];

    initial begin
        int          endc, wcyc;
        logic [31:0] got, ins;

        tbl[0]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[1]  = '{4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        tbl[2]  = '{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        tbl[3]  = '{4'h3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        tbl[4]  = '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        tbl[5]  = '{4'h5, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
        tbl[6]  = '{4'h6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        tbl[7]  = '{4'h7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        tbl[8]  = '{4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        tbl[9]  = '{4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[10] = '{4'hA, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0};
`ifdef CPU_MUL_EN
        tbl[11] = '{4'hB, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
`else
        tbl[11] = '{4'hB, 32'h0000_0007, 32'h0000_0006, 32'h0000_0006};
`endif
        tbl[12] = '{4'hF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002};

        // ALU table: load operands, operate, store result
        for (int t = 0; t < 13; t++) begin
            clear_image();
            image[0] = enc(4'h2, 4'h0, 4'd1, 4'd0, 16'h0080);
            image[1] = enc(4'h2, 4'h0, 4'd2, 4'd0, 16'h0081);
            image[2] = enc(4'h0, tbl[t].fn, 4'd3, 4'd1, 16'h2000);
            image[3] = enc(4'h3, 4'h0, 4'd3, 4'd0, 16'h0082);
            image[4] = enc(4'hF, 4'h0, 4'd0, 4'd0, 16'h0000);
            image[8'h80] = tbl[t].a;
            image[8'h81] = tbl[t].b;
            run_prog(25);
            find_store(30'h82, got);
            check($sformatf("alu_tbl%0d_fn%h", t, tbl[t].fn), got, tbl[t].exp);
        end

        // Arithmetic, store/load and HALT at address 10
        clear_image();
        image[0]  = enc(4'h1, 4'h0, 4'd1, 4'd0, 16'd5);
        image[1]  = enc(4'h1, 4'h0, 4'd2, 4'd1, 16'hFFF9);
        image[2]  = enc(4'h0, 4'h8, 4'd3, 4'd2, 16'h0000);
        image[3]  = enc(4'h0, 4'h9, 4'd4, 4'd2, 16'h1000);
        image[4]  = enc(4'h3, 4'h0, 4'd2, 4'd0, 16'h0080);
        image[5]  = enc(4'h2, 4'h0, 4'd5, 4'd0, 16'h0080);
        image[6]  = enc(4'h3, 4'h0, 4'd3, 4'd0, 16'h0081);
        image[7]  = enc(4'h3, 4'h0, 4'd4, 4'd0, 16'h0082);
        image[8]  = enc(4'h3, 4'h0, 4'd5, 4'd0, 16'h0083);
        image[9]  = enc(4'h9, 4'h0, 4'd0, 4'd0, 16'h0000);
        image[10] = enc(4'hF, 4'h0, 4'd0, 4'd0, 16'h0000);
        model_run(endc);
        run_prog(endc + 50);
        check_trace("prog_arith");
        find_store(30'h80, got); check("arith_r2", got, 32'hFFFF_FFFE);
        find_store(30'h81, got); check("arith_slt", got, 32'h0000_0001);
        find_store(30'h82, got); check("arith_sltu", got, 32'h0000_0000);
        find_store(30'h83, got); check("arith_load", got, 32'hFFFF_FFFE);
        check("halt_quiet", {30'd0, mem_re, mem_we}, 32'd0);

        // Reset asserted during the store EXEC cycle drops outputs at once
        wcyc = 0;
        foreach (exp_q[i]) if (exp_q[i].we && wcyc == 0) wcyc = exp_q[i].cyc;
        run_prog(wcyc);
        check("abort_pre_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_memaddr", {2'b00, memaddr}, 32'd0);
        check("abort_wmemdata", wmemdata, 32'd0);

        // Countdown loop, jump-register link, always/never branches
        clear_image();
        image[0]  = enc(4'h1, 4'h0, 4'd1, 4'd0, 16'd3);
        image[1]  = enc(4'h1, 4'h1, 4'd1, 4'd1, 16'd1);
        image[2]  = enc(4'h4, 4'h2, 4'd7, 4'd1, 16'hFFFE);
        image[3]  = enc(4'h3, 4'h0, 4'd1, 4'd0, 16'h0080);
        image[4]  = enc(4'h3, 4'h0, 4'd7, 4'd0, 16'h0081);
        image[5]  = enc(4'h1, 4'h0, 4'd9, 4'd0, 16'd8);
        image[6]  = enc(4'h5, 4'h0, 4'd8, 4'd9, 16'h0000);
        image[7]  = enc(4'hF, 4'h0, 4'd0, 4'd0, 16'h0000);
        image[8]  = enc(4'h3, 4'h0, 4'd8, 4'd0, 16'h0082);
        image[9]  = enc(4'h4, 4'h0, 4'd0, 4'd0, 16'h0001);
        image[10] = enc(4'h3, 4'h0, 4'd1, 4'd0, 16'h0090);
        image[11] = enc(4'h4, 4'h5, 4'd10, 4'd0, 16'h0005);
        image[12] = enc(4'h3, 4'h0, 4'd10, 4'd0, 16'h0083);
        image[13] = enc(4'hF, 4'h0, 4'd0, 4'd0, 16'h0000);
        model_run(endc);
        run_prog(endc + 50);
        check_trace("prog_branch");
        find_store(30'h80, got); check("loop_count", got, 32'd0);
        find_store(30'h81, got); check("branch_link", got, 32'd3);
        find_store(30'h82, got); check("jreg_link", got, 32'd7);
        find_store(30'h83, got); check("never_link", got, 32'd12);

        // LUI/ORI, zero-extended OR via SHR, SAR, MUL
        clear_image();
        image[0]  = enc(4'h6, 4'h0, 4'd6, 4'd0, 16'hDEAD);
        image[1]  = enc(4'h1, 4'h3, 4'd7, 4'd6, 16'hBEEF);
        image[2]  = enc(4'h6, 4'h0, 4'd8, 4'd0, 16'hBEEF);
        image[3]  = enc(4'h1, 4'h6, 4'd8, 4'd8, 16'd16);
        image[4]  = enc(4'h0, 4'h3, 4'd9, 4'd6, 16'h8000);
        image[5]  = enc(4'h6, 4'h0, 4'd10, 4'd0, 16'h8000);
        image[6]  = enc(4'h1, 4'h7, 4'd10, 4'd10, 16'd4);
        image[7]  = enc(4'h1, 4'h0, 4'd11, 4'd0, 16'd7);
        image[8]  = enc(4'h1, 4'h0, 4'd12, 4'd0, 16'd6);
        image[9]  = enc(4'h0, 4'hB, 4'd13, 4'd11, 16'hC000);
        image[10] = enc(4'h3, 4'h0, 4'd7, 4'd0, 16'h0080);
        image[11] = enc(4'h3, 4'h0, 4'd9, 4'd0, 16'h0081);
        image[12] = enc(4'h3, 4'h0, 4'd10, 4'd0, 16'h0082);
        image[13] = enc(4'h3, 4'h0, 4'd13, 4'd0, 16'h0083);
        image[14] = enc(4'hF, 4'h0, 4'd0, 4'd0, 16'h0000);
        model_run(endc);
        run_prog(endc + 50);
        check_trace("prog_lui");
        find_store(30'h80, got); check("ori_sext", got, 32'hFFFF_BEEF);
        find_store(30'h81, got); check("lui_or", got, 32'hDEAD_BEEF);
        find_store(30'h82, got); check("sar", got, 32'hF800_0000);
`ifdef CPU_MUL_EN
        find_store(30'h83, got); check("mul", got, 32'd42);
`else
        find_store(30'h83, got); check("mul", got, 32'd6);
`endif

        // Random ALU/LUI programs; every register is stored at the end
        for (int p = 0; p < 20; p++) begin
            clear_image();
            for (int i = 0; i < 12; i++) begin
                case ($urandom_range(0, 2))
                    0:       ins = enc(4'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                       4'($urandom_range(0, 15)), 16'($urandom));
                    1:       ins = enc(4'h1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                       4'($urandom_range(0, 15)), 16'($urandom));
                    default: ins = enc(4'h6, 4'h0, 4'($urandom_range(0, 15)), 4'd0, 16'($urandom));
                endcase
                image[i] = ins;
            end
            for (int r = 1; r < 16; r++)
                image[11 + r] = enc(4'h3, 4'h0, 4'(r), 4'd0, 16'h0080 + 16'(r));
            image[27] = enc(4'hF, 4'h0, 4'd0, 4'd0, 16'h0000);
            model_run(endc);
            run_prog(endc + 50);
            check_trace($sformatf("rand%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
